// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N valid/ready stream demultiplexer with broadcast.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      input handshake; in_data word, in_sel channel, in_bcast all channels
//   out_valid/out_ready    per-channel handshake; out_data packs channel k at [k*WIDTH +: WIDTH]
//   drop_cnt, sel_err      saturating count and one-cycle pulse for out-of-range selects
module demux_stream_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               sel_err
);
    localparam logic [SEL_W:0] NL = (SEL_W+1)'(N);
    logic [N-1:0]       r_valid;
    logic [N*WIDTH-1:0] r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [N-1:0]       w_can_load;
    logic [N-1:0]       w_hit;
    logic [N-1:0]       w_load;
    logic               w_in_range;
    logic               w_acc;
    logic               w_drop;
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N; k++) w_hit[k] = (in_sel == SEL_W'(k));
    end
    assign w_can_load = ~r_valid | out_ready;
    assign w_in_range = {1'b0, in_sel} < NL;
    // out-of-range unicasts are swallowed so a bad select never stalls the producer
    assign in_ready   = in_bcast ? &w_can_load : (w_in_range ? |(w_hit & w_can_load) : 1'b1);
    assign w_acc      = in_valid && in_ready;
    assign w_load     = {N{w_acc}} & (in_bcast ? {N{1'b1}} : w_hit);
    assign w_drop     = w_acc && !in_bcast && !w_in_range;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_load | (r_valid & ~out_ready);
            for (int k = 0; k < N; k++)
                if (w_load[k]) r_data[k*WIDTH +: WIDTH] <= in_data;
            if (w_drop && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            r_err <= w_drop;
        end
    end
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_cnt  = r_cnt;
    assign sel_err   = r_err;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn: randomized and directed check of demux_stream_1xn against a channel-array model.
// Two instances share stimulus: N=16/CNT_W=8 (all selects valid) and N=10/CNT_W=2 (selects 10..15 drop).
module tb_demux_stream_1xn;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_bcast;
    logic [7:0]   in_data;
    logic [3:0]   in_sel;
    logic [15:0]  out_ready;
    logic         rdy_a, rdy_b, se_a, se_b;
    logic [15:0]  ov_a;
    logic [9:0]   ov_b;
    logic [127:0] od_a;
    logic [79:0]  od_b;
    logic [7:0]   dc_a;
    logic [1:0]   dc_b;
    always #5 clk = ~clk;
    demux_stream_1xn #(.WIDTH(8), .N(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .drop_cnt(dc_a), .sel_err(se_a));
    demux_stream_1xn #(.WIDTH(8), .N(10), .CNT_W(2)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov_b), .out_ready(out_ready[9:0]),
        .out_data(od_b), .drop_cnt(dc_b), .sel_err(se_b));
    int n_pass = 0;
    int n_chk = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // model: per instance, an array of channel slots (full flag + word) plus drop bookkeeping
    int       nn[2]   = '{16, 10};
    int       cmax[2] = '{255, 3};
    bit       mv[2][16];
    bit [7:0] md[2][16];
    int       mc[2];
    bit       me[2];
    bit       mr[2];
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) begin
                mv[i][k] = 0;
                md[i][k] = 0;
            end
            mc[i] = 0;
            me[i] = 0;
        end
    endtask
    function automatic bit exp_ready(input int i);
        bit all_free = 1;
        for (int k = 0; k < nn[i]; k++) if (mv[i][k] && !out_ready[k]) all_free = 0;
        if (in_bcast) return all_free;
        if (int'(in_sel) >= nn[i]) return 1;
        return !mv[i][in_sel] || out_ready[in_sel];
    endfunction
    task automatic check_outs();
        logic [15:0] ev;
        for (int i = 0; i < 2; i++) begin
            ev = '0;
            for (int k = 0; k < nn[i]; k++) begin
                ev[k] = mv[i][k];
                check($sformatf("data%0d[%0d]", i, k), i ? od_b[k*8 +: 8] : od_a[k*8 +: 8], md[i][k]);
            end
            check($sformatf("valid%0d", i), i ? {6'd0, ov_b} : ov_a, ev);
            check($sformatf("drop_cnt%0d", i), i ? dc_b : dc_a, mc[i]);
            check($sformatf("sel_err%0d", i), i ? se_b : se_a, me[i]);
        end
    endtask
    // one clock of stimulus, entered and left on a falling edge
    task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] s, input bit b, input logic [15:0] r);
        bit acc;
        check_outs();
        in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
        #1;
        for (int i = 0; i < 2; i++) begin
            mr[i] = exp_ready(i);
            check($sformatf("in_ready%0d", i), i ? rdy_b : rdy_a, mr[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            acc = v && mr[i];
            for (int k = 0; k < nn[i]; k++) begin
                if (acc && (b || int'(s) == k)) begin
                    mv[i][k] = 1;
                    md[i][k] = d;
                end else if (r[k]) mv[i][k] = 0;
            end
            me[i] = acc && !b && int'(s) >= nn[i];
            if (me[i] && mc[i] < cmax[i]) mc[i]++;
        end
        @(negedge clk);
    endtask
    initial begin
        rst = 1; in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = '0;
        model_reset();
        #12;
        check("rst_valid", ov_a, 16'h0);
        check("rst_drop", dc_a, 8'h0);
        check("rst_ready_a", rdy_a, 1'b1);
        check("rst_ready_b", rdy_b, 1'b1);
        @(negedge clk);
        rst = 0;
        cycle(0, 8'h00, 4'd0, 0, 16'h0000);
        for (int k = 0; k < 16; k++) cycle(1, 8'hA0 + 8'(k), 4'(k), 0, 16'hFFFF);
        cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        cycle(1, 8'h11, 4'd3, 0, 16'hFFF7);
        cycle(1, 8'h22, 4'd3, 0, 16'hFFF7);
        check("bp_stall", rdy_a, 1'b0);
        cycle(1, 8'h33, 4'd5, 0, 16'hFFF7);
        cycle(1, 8'h22, 4'd3, 0, 16'hFFFF);
        check("bp_reload_valid", ov_a[3], 1'b1);
        check("bp_reload_data", od_a[31:24], 8'h22);
        cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        cycle(1, 8'h5A, 4'd0, 1, 16'hFFFF);
        check("bcast_all", ov_a, 16'hFFFF);
        cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        cycle(1, 8'h77, 4'd7, 0, 16'hFF7F);
        cycle(1, 8'h5A, 4'd0, 1, 16'hFF7F);
        check("bcast_stall", rdy_a, 1'b0);
        cycle(1, 8'h5A, 4'd0, 1, 16'hFFFF);
        cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        for (int j = 0; j < 6; j++) cycle(1, 8'hEE, 4'd12, 0, 16'hFFFF);
        cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        check("drop_sat", dc_b, 2'd3);
        for (int j = 0; j < 3000; j++)
            cycle(($urandom % 4) != 0, 8'($urandom), 4'($urandom), ($urandom % 8) == 0,
                  16'($urandom | $urandom));
        for (int k = 0; k < 4; k++) cycle(1, 8'hC0 + 8'(k), 4'(k), 0, 16'h0000);
        #1 rst = 1;
        #1;
        check("mid_rst_valid_a", ov_a, 16'h0);
        check("mid_rst_data_a", od_a[63:0], 64'h0);
        check("mid_rst_valid_b", {6'd0, ov_b}, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int j = 0; j < 3; j++) cycle(0, 8'h00, 4'd0, 0, 16'hFFFF);
        check_outs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/demux_stream_1xn.md
# demux_stream_1xn

Parametrised, registered 1-to-N stream demultiplexer. It routes a WIDTH-bit data word from one valid/ready input to one of N output channels, or to all of them in broadcast mode. Each channel has its own one-entry output register with independent backpressure. It succeeds the fixed 1x16 select-line demultiplexers and is used wherever a single producer feeds several independent consumers.

## Interface
- WIDTH, default 8: data word width in bits, must be >= 1
- N, default 16: number of output channels, 2..256, need not be a power of two
- SEL_W, default $clog2(N): select width, derived, never overridden
- CNT_W, default 8: width of the drop counter

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clears all state
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination channel index
- in_bcast  input  1  1 = deliver to every channel; in_sel is ignored
- out_valid  output  N  per-channel word present
- out_ready  input  N  per-channel consumer accept
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- drop_cnt  output  CNT_W  number of words dropped for an out-of-range select; saturates
- sel_err  output  1  one-cycle pulse on each drop

## Operation
- Channel k can load when `can_load[k] = !out_valid[k] || out_ready[k]`, meaning the register is empty or being drained this cycle.
- Unicast, in_bcast=0, in_sel < N:
  - in_ready = can_load[in_sel].
  - On accept, channel in_sel loads in_data and its out_valid is set.
- Broadcast, in_bcast=1:
  - in_ready = AND of can_load over all N channels.
  - On accept, every channel loads in_data and every out_valid is set in the same cycle.
  - Broadcast is all-or-nothing: no channel ever loads a partial broadcast.
- Out-of-range select, in_bcast=0, in_sel >= N (possible only when N is not a power of two):
  - in_ready = 1 and the word is consumed without being delivered.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - sel_err pulses high for one cycle.
- Channel drain: when out_valid[k] && out_ready[k] and no new load targets k, out_valid[k] clears on the next edge.
  - A simultaneous drain and load keeps out_valid[k]=1 and replaces the data, giving full throughput.
- out_data[k] holds its value whenever out_valid[k]=0; consumers must not sample it then.
- in_ready may depend combinationally on in_sel, in_bcast and out_ready; no output depends combinationally on in_data.
- Channels are fully independent: a stalled channel blocks only unicasts aimed at it, and any broadcast.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - out_valid = 0
  - out_data = 0
  - drop_cnt = 0
  - sel_err = 0
  - in_ready then follows from the above, so it is 1 during and after reset.
- Latency: a word accepted at edge t has out_valid[k]=1 and out_data[k] valid after edge t, i.e. 1 cycle.
- Throughput: one word per cycle per channel when the consumer holds out_ready=1.
  - Aggregate input throughput is one word per cycle.
- sel_err asserts the cycle after the dropping accept and deasserts one cycle later unless another drop occurs.
- drop_cnt updates on the same edge that sel_err is registered.
- Reset asserted mid-transfer discards every held word immediately; no word is delivered after reset.
- in_valid low: no state changes except drains.

## Test plan
- Reset and idle:
  - Assert rst with all out_ready=0 -> out_valid=0, drop_cnt=0, in_ready=1.
  - Release rst -> values unchanged.
- Unicast sweep, N=16, WIDTH=8, all out_ready=1:
  - Send data 8'hA0+k to in_sel=k for k=0..15 on consecutive cycles.
  - -> Exactly one out_valid bit is high each cycle, one cycle later, with out_data[k]=8'hA0+k; no gaps.
- Backpressure:
  - Hold out_ready[3]=0, send 8'h11 then 8'h22 to sel=3.
  - -> First word accepted; in_ready=0 for the second.
  - Meanwhile a send to sel=5 is accepted.
  - Raise out_ready[3] -> 8'h11 drains, 8'h22 loads on the same edge, out_valid[3] stays 1.
- Broadcast:
  - All out_ready=1, send in_bcast=1 data 8'h5A -> all 16 out_valid high for one cycle with 8'h5A.
  - Repeat with out_ready[7]=0 and channel 7 full -> in_ready=0 and no channel loads until channel 7 drains.
- Out-of-range, N=10:
  - Send in_sel=12 three times -> no out_valid, sel_err pulses three times, drop_cnt=3.
  - With CNT_W=2, six drops -> drop_cnt saturates at 3.
- Reset mid-operation:
  - Fill channels 0..3 with out_ready=0, assert rst asynchronously between edges.
  - -> out_valid=0 immediately, out_data=0, nothing delivered after release.
